sram_port_arbiter: RTL and testbench

// Shares the single port of sram1024x32_wrapper between two requesters: port 0 = accelerator datapath
// (weight loader / inference engine), port 1 = AHB slave register/buffer logic. Sits between ai_accelerator

---
 rtl/sram_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares the single port of the SRAM wrapper between two requesters:
// port 0 = accelerator datapath, port 1 = AHB slave register/buffer logic.
// One 32-bit access is in flight at a time. The access rides the wrapper's
// sram_state handshake and returns done/err/rdata to the owning requester.
//
// Ports
//   clk, n_rst                      clock, asynchronous active-low reset
//   reqN/wenN/addrN/wdataN          requester N command (held until doneN)
//   doneN/errN/rdataN               requester N completion, error, read data
//   address/read_enable/
//   write_enable/write_data         command to the SRAM wrapper
//   read_data/sram_state            response from the SRAM wrapper
//                                   (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
//   busy/owner                      arbiter busy, currently granted port
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: alternate grants on simultaneous requests.
//                       undefined: fixed priority, port 0 over port 1.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wen0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address,
    output logic              read_enable,
    output logic              write_enable,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic [1:0]        sram_state,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] SRAM_ACCESS = 2'd2;
    localparam logic [1:0] SRAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic               cmd_wen, cmd_wen_d;
    logic               last_grant, last_grant_d;
    logic [CNT_W-1:0]   count, count_d;
    logic [ADDR_W-1:0]  address_d;
    logic [DATA_W-1:0]  write_data_d;
    logic               read_enable_d, write_enable_d;
    logic               owner_d, busy_d;
    logic               done0_d, done1_d, err0_d, err1_d;
    logic [DATA_W-1:0]  rdata0_d, rdata1_d;
    logic               winner_c;
    logic               finish_c, fail_c;
    logic               sel_wen_c;

    // Winner among the current requesters (only meaningful when req0|req1)
`ifdef ARB_ROUND_ROBIN_EN
    assign winner_c = (req0 & req1) ? ~last_grant : req1;
`else
    assign winner_c = ~req0;
`endif

    assign sel_wen_c = winner_c ? wen1 : wen0;

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        cmd_wen_d      = cmd_wen;
        last_grant_d   = last_grant;
        count_d        = count;
        address_d      = address;
        write_data_d   = write_data;
        read_enable_d  = read_enable;
        write_enable_d = write_enable;
        owner_d        = owner;
        busy_d         = busy;
        rdata0_d       = rdata0;
        rdata1_d       = rdata1;
        done0_d        = 1'b0;
        done1_d        = 1'b0;
        err0_d         = 1'b0;
        err1_d         = 1'b0;
        finish_c       = 1'b0;
        fail_c         = 1'b0;

        case (state)
            ST_IDLE: begin
                // The done cycle itself is not arbitrated, giving the finished
                // requester one cycle to drop req.
                if ((req0 | req1) && !(done0 | done1)) begin
                    address_d      = winner_c ? addr1 : addr0;
                    write_data_d   = winner_c ? wdata1 : wdata0;
                    cmd_wen_d      = sel_wen_c;
                    read_enable_d  = ~sel_wen_c;
                    write_enable_d = sel_wen_c;
                    owner_d        = winner_c;
                    last_grant_d   = winner_c;
                    busy_d         = 1'b1;
                    count_d        = '0;
                    state_d        = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sram_state == SRAM_ACCESS) begin
                    finish_c = 1'b1;
                end else if (sram_state == SRAM_ERROR) begin
                    finish_c = 1'b1;
                    fail_c   = 1'b1;
                end else if (count == CNT_W'(TIMEOUT - 1)) begin
                    finish_c = 1'b1;
                    fail_c   = 1'b1;
                end else begin
                    count_d = CNT_W'(count + 1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion: release the wrapper and report to the owner
        if (finish_c) begin
            read_enable_d  = 1'b0;
            write_enable_d = 1'b0;
            busy_d         = 1'b0;
            state_d        = ST_IDLE;
            if (owner) begin
                done1_d = 1'b1;
                err1_d  = fail_c;
                if (!fail_c && !cmd_wen) rdata1_d = read_data;
            end else begin
                done0_d = 1'b1;
                err0_d  = fail_c;
                if (!fail_c && !cmd_wen) rdata0_d = read_data;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            cmd_wen      <= 1'b0;
            last_grant   <= 1'b1;
            count        <= '0;
            address      <= '0;
            write_data   <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            owner        <= 1'b0;
            busy         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
        end else begin
            state        <= state_d;
            cmd_wen      <= cmd_wen_d;
            last_grant   <= last_grant_d;
            count        <= count_d;
            address      <= address_d;
            write_data   <= write_data_d;
            read_enable  <= read_enable_d;
            write_enable <= write_enable_d;
            owner        <= owner_d;
            busy         <= busy_d;
            rdata0       <= rdata0_d;
            rdata1       <= rdata1_d;
            done0        <= done0_d;
            done1        <= done1_d;
            err0         <= err0_d;
            err1         <= err1_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter with a small SRAM wrapper model that
// answers BUSY then ACCESS, or forces ERROR / endless BUSY on demand.
module tb_sram_port_arbiter;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              req0, req1, wen0, wen1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              done0, done1, err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] address;
    logic              read_enable, write_enable;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic [1:0]        sram_state;
    logic              busy, owner;

    int vectors     = 0;
    int miscompares = 0;

    // SRAM model control: 0 normal, 1 answer ERROR, 2 stay BUSY forever
    int          mode;
    logic [1:0]  phase;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req0        (req0),
        .req1        (req1),
        .wen0        (wen0),
        .wen1        (wen1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .done0       (done0),
        .done1       (done1),
        .err0        (err0),
        .err1        (err1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .address     (address),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .write_data  (write_data),
        .read_data   (read_data),
        .sram_state  (sram_state),
        .busy        (busy),
        .owner       (owner)
    );

    function automatic logic [31:0] init_word(input logic [9:0] a);
        return 32'hA000_0000 | 32'(a);
    endfunction

    // Wrapper model: first enabled cycle -> BUSY, second -> ACCESS
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sram_state <= 2'd0;
            phase      <= 2'd0;
            read_data  <= 32'h0;
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
        end else if (read_enable | write_enable) begin
            if (mode == 1) begin
                sram_state <= 2'd3;
            end else if (mode == 2) begin
                sram_state <= 2'd1;
            end else if (phase == 2'd0) begin
                sram_state <= 2'd1;
                phase      <= 2'd1;
            end else if (phase == 2'd1) begin
                sram_state <= 2'd2;
                phase      <= 2'd2;
                if (write_enable) mem[address] <= write_data;
                else              read_data    <= mem[address];
            end else begin
                sram_state <= 2'd0;
            end
        end else begin
            sram_state <= 2'd0;
            phase      <= 2'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Invariants every cycle
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            check("enables_exclusive", 32'(read_enable & write_enable), 32'd0);
            check("done_exclusive", 32'(done0 & done1), 32'd0);
            if (!busy) check("idle_no_enable", 32'(read_enable | write_enable), 32'd0);
        end
    end

    // One access on port p; returns latency (edges from req to done), err and
    // the command seen on the wrapper port one edge after req.
    task automatic run_access(input logic p, input logic w, input logic [9:0] a,
                              input logic [31:0] d, output int lat, output logic e,
                              output logic g_re, output logic g_we,
                              output logic [9:0] g_addr, output logic g_own);
        int   n;
        logic got;
        if (p) begin req1 = 1'b1; wen1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; wen0 = w; addr0 = a; wdata0 = d; end
        n = 0; got = 1'b0;
        g_re = 1'b0; g_we = 1'b0; g_addr = '0; g_own = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                g_re = read_enable; g_we = write_enable; g_addr = address; g_own = owner;
            end
            got = p ? done1 : done0;
        end
        check("done_seen", 32'(got), 32'd1);
        lat = n;
        e   = p ? err1 : err0;
        check("done_cycle_enables_low", 32'(read_enable | write_enable), 32'd0);
        if (p) req1 = 1'b0; else req0 = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", 32'({done0, done1}), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int          lat;
        logic        e, g_re, g_we, g_own;
        logic [9:0]  g_addr;
        int          exp_order [8];
        int          cnt0, cnt1, n;

        n_rst = 1'b0; mode = 0;
        req0 = 1'b0; req1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_re", 32'(read_enable), 32'd0);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_done", 32'({done0, done1}), 32'd0);
        check("rst_err", 32'({err0, err1}), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy), 32'd0);

        // Port 1 write then read back
        run_access(1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF, lat, e, g_re, g_we, g_addr, g_own);
        check("wr1_latency", 32'(lat), 32'd4);
        check("wr1_err", 32'(e), 32'd0);
        check("wr1_we", 32'(g_we), 32'd1);
        check("wr1_re", 32'(g_re), 32'd0);
        check("wr1_addr", 32'(g_addr), 32'h010);
        check("wr1_owner", 32'(g_own), 32'd1);
        check("wr1_mem", mem[10'h010], 32'hDEAD_BEEF);
        run_access(1'b1, 1'b0, 10'h010, 32'h0, lat, e, g_re, g_we, g_addr, g_own);
        check("rd1_latency", 32'(lat), 32'd4);
        check("rd1_err", 32'(e), 32'd0);
        check("rd1_re", 32'(g_re), 32'd1);
        check("rd1_we", 32'(g_we), 32'd0);
        check("rd1_rdata1", rdata1, 32'hDEAD_BEEF);
        check("rd1_rdata0", rdata0, 32'd0);

        // Port 0 good read, then a read the wrapper answers with ERROR
        run_access(1'b0, 1'b0, 10'h005, 32'h0, lat, e, g_re, g_we, g_addr, g_own);
        check("rd0_owner", 32'(g_own), 32'd0);
        check("rd0_err", 32'(e), 32'd0);
        check("rd0_rdata0", rdata0, 32'hA000_0005);
        mode = 1;
        run_access(1'b0, 1'b0, 10'h020, 32'h0, lat, e, g_re, g_we, g_addr, g_own);
        mode = 0;
        check("err0_latency", 32'(lat), 32'd3);
        check("err0_err", 32'(e), 32'd1);
        check("err0_rdata0", rdata0, 32'hA000_0005);

        // Wrapper stuck BUSY: forced abort TIMEOUT cycles after WAIT entry
        mode = 2;
        run_access(1'b1, 1'b0, 10'h030, 32'h0, lat, e, g_re, g_we, g_addr, g_own);
        mode = 0;
        check("tmo_latency", 32'(lat), 32'(TIMEOUT + 2));
        check("tmo_err", 32'(e), 32'd1);
        check("tmo_rdata1", rdata1, 32'hDEAD_BEEF);

        // Both ports requesting continuously, four reads each
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        cnt0 = 0; cnt1 = 0;
        wen0 = 1'b0; wen1 = 1'b0;
        addr0 = 10'h100; addr1 = 10'h200;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!(done0 | done1) && n < 200);
            check("arb_done_seen", 32'(done0 | done1), 32'd1);
            check("arb_order", 32'(done1), 32'(exp_order[k]));
            if (done0) begin
                check("arb_rdata0", rdata0, init_word(10'(10'h100 + cnt0)));
                cnt0++;
                if (cnt0 == 4) req0 = 1'b0; else addr0 = 10'(10'h100 + cnt0);
            end
            if (done1) begin
                check("arb_rdata1", rdata1, init_word(10'(10'h200 + cnt1)));
                cnt1++;
                if (cnt1 == 4) req1 = 1'b0; else addr1 = 10'(10'h200 + cnt1);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("arb_idle", 32'(busy), 32'd0);

        // Reset in the middle of WAIT aborts silently
        mode = 2;
        req0 = 1'b1; wen0 = 1'b0; addr0 = 10'h040;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(busy), 32'd1);
        check("midrst_addr_before", 32'(address), 32'h040);
        n_rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_re", 32'(read_enable), 32'd0);
        check("midrst_address", 32'(address), 32'd0);
        check("midrst_rdata1", rdata1, 32'd0);
        check("midrst_rdata0", rdata0, 32'd0);
        check("midrst_done", 32'({done0, done1}), 32'd0);
        req0 = 1'b0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_done", 32'({done0, done1}), 32'd0);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_release_busy", 32'(busy), 32'd0);
        check("midrst_release_done", 32'({done0, done1}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
